// File: rtl/nc_ddsm_pkg.sv
// Shared constants, types and helpers for the NC-DDSM MASH modulator stages.
// Optional build macro affecting users of this package: NC_MASH_STAGE3_EN.
package nc_ddsm_pkg;

    localparam int Y_WIDTH = 4;

    typedef logic signed [Y_WIDTH-1:0] nc_y_t;

    // Enabled cycles until the first output fed entirely by aligned carries.
    function automatic int fill_cycles(input int skew, input bit stage3_en);
        return stage3_en ? (2 * skew + 2) : (skew + 2);
    endfunction

endpackage

// File: rtl/mash_delay_line.sv
// Enable-gated single-bit shift register of depth D with synchronous clear.
// D = 0 is a combinational pass-through.
module mash_delay_line #(
    parameter int D = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    input  logic i_d,
    output logic o_q
);

    generate
        if (D == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = i_clk ^ i_rst_n ^ i_en ^ i_clr;
            assign o_q = i_d;
        end else begin : g_sr
            logic [D-1:0] sr;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    sr <= '0;
                end else if (i_clr) begin
                    sr <= '0;
                end else if (i_en) begin
                    sr[0] <= i_d;
                    for (int unsigned i = 1; i < D; i++) begin
                        sr[i] <= sr[i-1];
                    end
                end
            end

            assign o_q = sr[D-1];
        end
    endgenerate

endmodule

// File: rtl/mash_noise_cancel.sv
// MASH carry alignment, noise-cancel differentiation and integer recombination.
// Build macro NC_MASH_STAGE3_EN selects 1-1-1 (defined) or 1-1 (undefined).
module mash_noise_cancel
    import nc_ddsm_pkg::*;
#(
    parameter int P_INT_WIDTH = 8,
    parameter int P_SKEW      = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_en,
    input  logic                   i_clr,
    input  logic [P_INT_WIDTH-1:0] i_n_int,
    input  logic                   i_c1,
    input  logic                   i_c2,
    input  logic                   i_c3,
    output logic [P_INT_WIDTH:0]   o_div,
    output logic                   o_valid,
    output logic                   o_ovf
);

`ifdef NC_MASH_STAGE3_EN
    localparam bit STAGE3 = 1'b1;
`else
    localparam bit STAGE3 = 1'b0;
`endif

    localparam int C1_DELAY = STAGE3 ? 2 * P_SKEW : P_SKEW;
    localparam int FILL     = fill_cycles(P_SKEW, STAGE3);
    localparam int CNT_W    = $clog2(FILL + 1);
    localparam int SUM_W    = P_INT_WIDTH + 2;

    logic             c1a;
    logic             c2a;
    logic             c2a_z1;
    nc_y_t            d2;
    nc_y_t            d3;
    nc_y_t            y;
    logic [SUM_W-1:0] sum;
    logic             sum_neg;
    logic [CNT_W-1:0] fill_cnt;

    mash_delay_line #(.D(C1_DELAY)) u_c1_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_clr   (i_clr),
        .i_d     (i_c1),
        .o_q     (c1a)
    );

    mash_delay_line #(.D(P_SKEW)) u_c2_dly (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_clr   (i_clr),
        .i_d     (i_c2),
        .o_q     (c2a)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            c2a_z1 <= 1'b0;
        end else if (i_clr) begin
            c2a_z1 <= 1'b0;
        end else if (i_en) begin
            c2a_z1 <= c2a;
        end
    end

    assign d2 = nc_y_t'({3'b000, c2a}) - nc_y_t'({3'b000, c2a_z1});

`ifdef NC_MASH_STAGE3_EN
    logic c3_z1;
    logic c3_z2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            c3_z1 <= 1'b0;
            c3_z2 <= 1'b0;
        end else if (i_clr) begin
            c3_z1 <= 1'b0;
            c3_z2 <= 1'b0;
        end else if (i_en) begin
            c3_z1 <= i_c3;
            c3_z2 <= c3_z1;
        end
    end

    assign d3 = nc_y_t'({3'b000, i_c3}) - nc_y_t'({2'b00, c3_z1, 1'b0})
              + nc_y_t'({3'b000, c3_z2});
`else
    logic unused_c3;
    assign unused_c3 = i_c3;
    assign d3 = '0;
`endif

    // 4-bit wraparound is exact because y stays within -3..+4.
    assign y       = nc_y_t'({3'b000, c1a}) + d2 + d3;
    assign sum     = {2'b00, i_n_int} + {{(SUM_W - Y_WIDTH){y[Y_WIDTH-1]}}, y};
    assign sum_neg = sum[SUM_W-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_div <= '0;
            o_ovf <= 1'b0;
        end else if (i_clr) begin
            o_div <= '0;
            o_ovf <= 1'b0;
        end else if (i_en) begin
            if (sum_neg) begin
                o_div <= '0;
                o_ovf <= 1'b1;
            end else begin
                o_div <= sum[P_INT_WIDTH:0];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fill_cnt <= '0;
        end else if (i_clr) begin
            fill_cnt <= '0;
        end else if (i_en && (fill_cnt != CNT_W'(FILL))) begin
            fill_cnt <= fill_cnt + 1'b1;
        end
    end

    assign o_valid = (fill_cnt == CNT_W'(FILL));

endmodule

// File: tb/tb_mash_noise_cancel.sv
// Directed bench for mash_noise_cancel; expectations follow NC_MASH_STAGE3_EN.
module tb_mash_noise_cancel;

    localparam int P_INT_WIDTH = 8;
    localparam int P_SKEW      = 1;
`ifdef NC_MASH_STAGE3_EN
    localparam int D1   = 2 * P_SKEW;
    localparam int FILL = 2 * P_SKEW + 2;
`else
    localparam int D1   = P_SKEW;
    localparam int FILL = P_SKEW + 2;
`endif
    localparam int D2   = P_SKEW;
    localparam int NGAT = 24;

    logic                   i_clk = 1'b0;
    logic                   i_rst_n;
    logic                   i_en;
    logic                   i_clr;
    logic [P_INT_WIDTH-1:0] i_n_int;
    logic                   i_c1;
    logic                   i_c2;
    logic                   i_c3;
    logic [P_INT_WIDTH:0]   o_div;
    logic                   o_valid;
    logic                   o_ovf;

    int n_chk  = 0;
    int n_fail = 0;

    bit c1s [NGAT];
    bit c2s [NGAT];
    bit c3s [NGAT];

    mash_noise_cancel #(.P_INT_WIDTH(P_INT_WIDTH), .P_SKEW(P_SKEW)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_clr   (i_clr),
        .i_n_int (i_n_int),
        .i_c1    (i_c1),
        .i_c2    (i_c2),
        .i_c3    (i_c3),
        .o_div   (o_div),
        .o_valid (o_valid),
        .o_ovf   (o_ovf)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic en, input logic c1, input logic c2, input logic c3,
                        input logic clr = 1'b0);
        i_en  = en;
        i_c1  = c1;
        i_c2  = c2;
        i_c3  = c3;
        i_clr = clr;
        @(posedge i_clk);
        #1;
    endtask

    function automatic int smp(input int which, input int i);
        if (i < 0) return 0;
        case (which)
            1: return int'(c1s[i]);
            2: return int'(c2s[i]);
            default: return int'(c3s[i]);
        endcase
    endfunction

    // y for the k-th enabled sample after a clear, written directly from stream indices
    function automatic int y_ref(input int k);
        int y;
        y = smp(1, k - D1) + smp(2, k - D2) - smp(2, k - D2 - 1);
`ifdef NC_MASH_STAGE3_EN
        y += smp(3, k) - 2 * smp(3, k - 1) + smp(3, k - 2);
`endif
        return y;
    endfunction

    task automatic ovf_seq();
`ifdef NC_MASH_STAGE3_EN
        i_n_int = 8'd2;
        step(1, 0, 1, 0); chk("ovf_a_div", o_div, 2); chk("ovf_a_flag", o_ovf, 0);
        step(1, 0, 0, 1); chk("ovf_b_div", o_div, 4); chk("ovf_b_flag", o_ovf, 0);
        step(1, 0, 0, 0); chk("ovf_clamp_div", o_div, 0); chk("ovf_clamp_flag", o_ovf, 1);
        step(1, 0, 0, 0); chk("ovf_c_div", o_div, 3); chk("ovf_sticky1", o_ovf, 1);
        step(1, 0, 0, 0); chk("ovf_d_div", o_div, 2); chk("ovf_sticky2", o_ovf, 1);
`else
        i_n_int = 8'd0;
        step(1, 0, 1, 0); chk("ovf_a_div", o_div, 0); chk("ovf_a_flag", o_ovf, 0);
        step(1, 0, 0, 0); chk("ovf_b_div", o_div, 1); chk("ovf_b_flag", o_ovf, 0);
        step(1, 0, 0, 0); chk("ovf_clamp_div", o_div, 0); chk("ovf_clamp_flag", o_ovf, 1);
        step(1, 0, 0, 0); chk("ovf_c_div", o_div, 0); chk("ovf_sticky1", o_ovf, 1);
        step(1, 0, 0, 0); chk("ovf_d_div", o_div, 0); chk("ovf_sticky2", o_ovf, 1);
`endif
    endtask

    initial begin
        int prev_div;
        int prev_val;
        int idle;
        int expd;

        i_rst_n = 1'b0;
        i_en    = 1'b0;
        i_clr   = 1'b0;
        i_n_int = 8'd20;
        i_c1    = 1'b0;
        i_c2    = 1'b0;
        i_c3    = 1'b0;
        #22;
        chk("rst_div", o_div, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_ovf", o_ovf, 0);
        i_rst_n = 1'b1;

        // fill with all carries low
        for (int k = 1; k <= FILL + 2; k++) begin
            step(1, 0, 0, 0);
            chk("fill_div", o_div, 20);
            chk("fill_valid", o_valid, (k >= FILL) ? 1 : 0);
        end

        // single stage-3 pulse
`ifdef NC_MASH_STAGE3_EN
        step(1, 0, 0, 1); chk("c3_0", o_div, 21);
        step(1, 0, 0, 0); chk("c3_1", o_div, 18);
        step(1, 0, 0, 0); chk("c3_2", o_div, 21);
        step(1, 0, 0, 0); chk("c3_3", o_div, 20);
`else
        step(1, 0, 0, 1); chk("c3_ign0", o_div, 20);
        step(1, 0, 0, 0); chk("c3_ign1", o_div, 20);
        step(1, 0, 0, 0); chk("c3_ign2", o_div, 20);
`endif

        // c1 / c2 pulses presented with the native skew
`ifdef NC_MASH_STAGE3_EN
        step(1, 1, 0, 0); chk("c12_0", o_div, 20);
        step(1, 0, 1, 0); chk("c12_1", o_div, 20);
`else
        step(1, 1, 1, 0); chk("c12_0", o_div, 20);
`endif
        step(1, 0, 0, 0); chk("c12_a", o_div, 22);
        step(1, 0, 0, 0); chk("c12_b", o_div, 19);
        step(1, 0, 0, 0); chk("c12_c", o_div, 20);

        ovf_seq();

        // clear wins over enable and discards its own sample
        step(1, 1, 1, 1, 1'b1);
        chk("clr_div", o_div, 0);
        chk("clr_valid", o_valid, 0);
        chk("clr_ovf", o_ovf, 0);

        // random enable gating against an index-based reference
        i_n_int  = 8'd37;
        prev_div = 0;
        prev_val = 0;
        for (int k = 0; k < NGAT; k++) begin
            idle = int'($urandom_range(0, 2));
            for (int j = 0; j < idle; j++) begin
                step(0, 1'($urandom), 1'($urandom), 1'($urandom));
                chk("gate_hold_div", o_div, prev_div);
                chk("gate_hold_valid", o_valid, prev_val);
            end
            c1s[k] = 1'($urandom);
            c2s[k] = 1'($urandom);
            c3s[k] = 1'($urandom);
            step(1, c1s[k], c2s[k], c3s[k]);
            expd     = 37 + y_ref(k);
            prev_val = (k + 1 >= FILL) ? 1 : 0;
            prev_div = expd;
            chk("gate_div", o_div, expd);
            chk("gate_valid", o_valid, prev_val);
        end

        for (int j = 0; j < 4; j++) step(1, 0, 0, 0);
        ovf_seq();
        i_n_int = 8'd20;
        step(1, 0, 0, 0);
        chk("pre_rst_div", o_div, 20);

        // asynchronous reset in the middle of a cycle
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("arst_div", o_div, 0);
        chk("arst_valid", o_valid, 0);
        chk("arst_ovf", o_ovf, 0);
        #3;
        i_rst_n = 1'b1;
        #1;
        for (int k = 1; k <= FILL + 1; k++) begin
            step(1, 0, 0, 0);
            chk("refill_div", o_div, 20);
            chk("refill_valid", o_valid, (k >= FILL) ? 1 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mash_noise_cancel.md
# mash_noise_cancel

Noise-cancellation and recombination stage of the NC-DDSM MASH 1-1-1 modulator. It sits directly downstream of the three pipelined accumulator stages and consumes their carry-outs. It compensates the carry skew that the pipelined adders introduce, applies the (1−z⁻¹) and (1−z⁻¹)² differentiators, and adds the integer division ratio. The result is a registered, valid-qualified divider modulus for the PLL feedback divider.

## Interface
- P_INT_WIDTH, 8, width of integer division ratio i_n_int
- P_SKEW, 1, cycles by which each accumulator stage's carry lags the previous stage's carry
- i_clk  in  1  modulator clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_en  in  1  sample enable; every internal register advances only when high
- i_clr  in  1  synchronous clear of history, fill counter and overflow flag
- i_n_int  in  P_INT_WIDTH  integer divide ratio, unsigned
- i_c1  in  1  stage-1 carry
- i_c2  in  1  stage-2 carry, P_SKEW cycles later than i_c1
- i_c3  in  1  stage-3 carry, 2·P_SKEW cycles later than i_c1
- o_div  out  P_INT_WIDTH+1  divider modulus, unsigned
- o_valid  out  1  o_div is meaningful
- o_ovf  out  1  sticky flag: N+y went below 0 and o_div was clamped

## Operation
- Alignment:
  - c1a = i_c1 delayed 2·P_SKEW enabled cycles.
  - c2a = i_c2 delayed P_SKEW enabled cycles.
  - i_c3 is used undelayed.
- Differentiators, with history advancing on i_en:
  - d2 = c2a − c2a_z1, range −1..1.
  - d3 = c3 − 2·c3_z1 + c3_z2, range −2..2.
- y = c1a + d2 + d3: 4-bit two's complement, range −3..+4. All intermediate sums are sign-extended to 4 bits.
- div_next = zero-extended i_n_int + sign-extended y, computed at P_INT_WIDTH+2 bits.
  - If the result is negative, o_div loads 0 and o_ovf sets.
  - Otherwise o_div loads the low P_INT_WIDTH+1 bits. Upper overflow is impossible.
- Fill counter:
  - Counts enabled cycles and saturates at FILL = 2·P_SKEW+2.
  - o_valid = 1 once the counter reaches FILL.
  - o_valid stays high until reset or i_clr.
- i_en = 0: all registers hold, including o_div, o_valid and o_ovf.
- i_clr = 1:
  - Zeroes delay lines, history, counter and o_ovf on the next edge. o_div = 0 and o_valid = 0.
  - Takes priority over i_en.
  - The sample presented in the same cycle is discarded.
- Reset: o_div = 0, o_valid = 0, o_ovf = 0, and all delay and history registers = 0.
  - Assertion mid-operation clears immediately, without waiting for a clock.

## Timing
- o_div is registered, and all outputs change only on the i_clk rising edge, except on reset.
- Latency in enabled cycles:
  - i_c3 → o_div: 1.
  - i_c2 → o_div: P_SKEW+1.
  - i_c1 → o_div: 2·P_SKEW+1.
  - i_n_int → o_div: 1. A change in i_n_int affects only the next output, with no glitch on other terms.
- o_valid rises on the same edge as the FILL-th enabled o_div update.
- Stalls via i_en do not alter alignment; skew is counted in enabled cycles.
- No backpressure: the consumer samples o_div every enabled cycle while o_valid = 1.

## Configuration
- NC_MASH_STAGE3_EN defined:
  - Full 1-1-1 recombination as above.
  - y range −3..+4.
- NC_MASH_STAGE3_EN undefined: MASH 1-1 recombination.
  - i_c3 is ignored and the c3 history registers are not built.
  - y = c1a + d2, range −1..+2, still carried as 4 bits.
  - c1a delay becomes P_SKEW and FILL becomes P_SKEW+2.

## Structure
- Shared package nc_ddsm_pkg holds:
  - the Y_WIDTH = 4 constant;
  - the FILL computation function taking (P_SKEW, stage3 enable);
  - the signed-y typedef used by all modulator stages.
- Sub-module mash_delay_line: a parameterised, i_en-gated shift register of depth D with clear. Depth 0 passes through. It is instantiated for the c1 and c2 alignment.

## Test plan
- Reset with i_n_int = 20 and P_SKEW = 1, then hold i_en = 1 with all carries 0:
  - o_valid rises on the 4th enabled edge.
  - o_div = 20 throughout.
- Single pulse i_c3 = 1 for one cycle with N = 20 → o_div sequence 21, 18, 21, 20 starting 1 cycle later.
- Pulses i_c1 and i_c2 applied with the stated skew (i_c1 at cycle t, i_c2 at t+1) → aligned response 22, then 19, then 20.
- N = 2 with a carry pattern yielding y = −3 → o_div = 0 and o_ovf = 1. The flag stays set after y returns to 0, and i_clr clears it.
- i_en toggled 1/0 randomly against the same carry stream as an ungated run → identical sequence of enabled o_div values.
- Reset asserted mid-stream → o_div, o_valid and o_ovf become 0 asynchronously. After release, the fill re-runs the full 4 cycles.
